// File: rtl/cp0_timer_pkg.sv
// cp0_timer_pkg: shared definitions for the CP0 countdown timer.
//   - register word addresses (addr = byte address bits [3:2])
//   - CTRL register layout, mode encodings, FSM state type
package cp0_timer_pkg;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam logic [1:0] TMR_RSVD   = 2'd3;

   // MODE 2/3 are not special: anything other than MODE_RELOAD is one-shot.
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   // CTRL bit layout: [3] IM, [2:1] MODE, [0] EN.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } type_TMR_CTRL;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } type_TMR_STATE;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: programmable 32-bit countdown timer feeding one CP0 HWInt line.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr[1:0]         register select (CTRL, PRESET, COUNT, reserved)
//   we, wdata[31:0]   single-cycle register write
//   rdata[31:0]       combinational read of the selected register
//   irq               registered interrupt request (pending & IM)
//   dbg_state_o       current FSM state, for observation only
// Bus handshake: there is no back-pressure; a write is taken on every rising
// edge where we=1, and rdata always reflects the registers after the last edge.
module cp0_timer
   import cp0_timer_pkg::*;
#(
   parameter logic [31:0] RELOAD_MIN = 32'd1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    addr,
   input  logic          we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          irq,
   output type_TMR_STATE dbg_state_o
);

   type_TMR_CTRL  ctrl_q,   ctrl_d;
   logic [31:0]   preset_q, preset_d;
   logic [31:0]   count_q,  count_d;
   type_TMR_STATE state_q,  state_d;
   logic          pend_q,   pend_d;
   logic          pulse_q,  pulse_d;   // pend_q was set by an auto-reload INT
   logic          irq_q;

   logic        wr_ctrl;
   logic        wr_preset;
   logic [31:0] reload_val;

   assign wr_ctrl    = we && (addr == TMR_CTRL);
   assign wr_preset  = we && (addr == TMR_PRESET);
   assign reload_val = (preset_q < RELOAD_MIN) ? RELOAD_MIN : preset_q;

   always_comb begin
      ctrl_d   = wr_ctrl   ? type_TMR_CTRL'(wdata[3:0]) : ctrl_q;
      preset_d = wr_preset ? wdata : preset_q;
      count_d  = count_q;
      state_d  = state_q;
      pulse_d  = 1'b0;
      pend_d   = pend_q;
      // Clears are applied first so that an INT set below overrides them.
      if (wr_ctrl || wr_preset || pulse_q) begin
         pend_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (ctrl_q.en) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_d = reload_val;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q.en) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            pend_d = 1'b1;
            if (ctrl_q.mode == MODE_RELOAD) begin
               pulse_d = 1'b1;
               // A same-cycle CTRL write with EN=0 stops the reload.
               state_d = ctrl_d.en ? ST_LOAD : ST_IDLE;
            end else begin
               state_d = ST_IDLE;
               // A same-cycle CTRL write keeps the value the CPU wrote.
               if (!wr_ctrl) begin
                  ctrl_d.en = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         pend_q   <= 1'b0;
         pulse_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         state_q  <= state_d;
         pend_q   <= pend_d;
         pulse_q  <= pulse_d;
         // Built from next-state values so irq rises on the same edge as pending.
         irq_q    <= pend_d & ctrl_d.im;
      end
   end

   always_comb begin
      case (addr)
         TMR_CTRL:   rdata = {28'd0, ctrl_q};
         TMR_PRESET: rdata = preset_q;
         TMR_COUNT:  rdata = count_q;
         default:    rdata = 32'd0;
      endcase
   end

   assign irq         = irq_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer: directed + randomized checks of cp0_timer against register
// shadows and closed-form timing (latency P+3, reload period P+2).
module tb_cp0_timer;
   import cp0_timer_pkg::*;

   logic          clk;
   logic          rst_n;
   logic [1:0]    addr;
   logic          we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          irq;
   type_TMR_STATE dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   cp0_timer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .we          (we),
      .wdata       (wdata),
      .rdata       (rdata),
      .irq         (irq),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic st_chk(input string tag, input type_TMR_STATE exp);
      chk(tag, {30'd0, dbg_state}, {30'd0, exp});
   endtask

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] sh_ctrl, sh_preset, d, p, eff;
   logic [1:0]  a;
   int          n, total;
   logic        found;

   initial begin
      addr = 2'd0; we = 1'b0; wdata = 32'd0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- reset state ----
      rd_chk("rst_ctrl",   TMR_CTRL,   32'd0);
      rd_chk("rst_preset", TMR_PRESET, 32'd0);
      rd_chk("rst_count",  TMR_COUNT,  32'd0);
      rd_chk("rst_rsvd",   TMR_RSVD,   32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      st_chk("rst_state", ST_IDLE);

      // ---- random register access with EN kept 0 ----
      sh_ctrl = 32'd0; sh_preset = 32'd0;
      for (int i = 0; i < 8; i++) begin
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == TMR_CTRL) d = d & 32'hFFFF_FFFE;
         wr(a, d);
         if (a == TMR_CTRL)   sh_ctrl   = d & 32'hF;
         if (a == TMR_PRESET) sh_preset = d;
         rd_chk("reg_ctrl",   TMR_CTRL,   sh_ctrl);
         rd_chk("reg_preset", TMR_PRESET, sh_preset);
         rd_chk("reg_count",  TMR_COUNT,  32'd0);
         rd_chk("reg_rsvd",   TMR_RSVD,   32'd0);
      end
      wr(TMR_CTRL, 32'd0);

      // ---- directed one-shot, PRESET=3 ----
      wr(TMR_PRESET, 32'd3);
      wr(TMR_CTRL, 32'h9);                 // e0
      tick();                              // e1
      for (int k = 0; k < 4; k++) begin
         tick();                           // e2..e5
         rd_chk("os_count", TMR_COUNT, 32'(3 - k));
         chk("os_irq_low", {31'd0, irq}, 32'd0);
      end
      tick();                              // e6
      chk("os_irq_rise", {31'd0, irq}, 32'd1);
      rd_chk("os_ctrl_en_clr", TMR_CTRL, 32'h8);
      repeat (3) tick();
      chk("os_irq_sticky", {31'd0, irq}, 32'd1);
      wr(TMR_CTRL, 32'h8);
      chk("os_irq_clear", {31'd0, irq}, 32'd0);

      // ---- random one-shot latency ----
      for (int i = 0; i < 4; i++) begin
         p   = 32'($urandom_range(0, 12));
         eff = (p < 32'd1) ? 32'd1 : p;
         wr(TMR_PRESET, p);
         wr(TMR_CTRL, 32'h9);
         n = 0; found = 1'b0;
         while (!found && n < 200) begin
            tick();
            n++;
            found = irq;
         end
         chk("rnd_os_found", {31'd0, found}, 32'd1);
         chk("rnd_os_latency", 32'(n), eff + 32'd3);
         wr(TMR_CTRL, 32'h8);
      end

      // ---- auto-reload: directed PRESET=2, then random presets ----
      for (int i = 0; i < 3; i++) begin
         p   = (i == 0) ? 32'd2 : 32'($urandom_range(0, 6));
         eff = (p < 32'd1) ? 32'd1 : p;
         wr(TMR_PRESET, p);
         wr(TMR_CTRL, 32'hB);              // e0
         exp_q.delete(); got_q.delete();
         for (int k = 0; k < 5; k++) exp_q.push_back(eff + 32'd3 + 32'(k) * (eff + 32'd2));
         total = int'(eff + 32'd3 + 32'd4 * (eff + 32'd2) + 32'd1);
         for (int c = 1; c <= total; c++) begin
            tick();
            if (irq) got_q.push_back(32'(c));
         end
         chk("ar_pulse_count", 32'(got_q.size()), 32'd5);
         while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk("ar_pulse_time", got_q.pop_front(), exp_q.pop_front());
         end
         rd_chk("ar_ctrl_en_kept", TMR_CTRL, 32'hB);
         wr(TMR_CTRL, 32'd0);
         repeat (3) tick();
         st_chk("ar_stop_state", ST_IDLE);
      end

      // ---- masked, zero preset ----
      wr(TMR_PRESET, 32'd0);
      wr(TMR_CTRL, 32'h1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("mask_irq_low", {31'd0, irq}, 32'd0);
      end
      rd_chk("mask_int_reached", TMR_CTRL, 32'd0);
      rd_chk("mask_count", TMR_COUNT, 32'd0);
      wr(TMR_CTRL, 32'h8);
      for (int k = 0; k < 3; k++) begin
         chk("mask_pend_cleared", {31'd0, irq}, 32'd0);
         tick();
      end

      // ---- pause / resume ----
      wr(TMR_PRESET, 32'd20);
      wr(TMR_CTRL, 32'h9);
      n = 0; found = 1'b0;
      while (!found && n < 100) begin
         addr = TMR_COUNT; #1;
         found = (rdata == 32'd6);
         if (!found) begin tick(); n++; end
      end
      chk("pause_reach6", {31'd0, found}, 32'd1);
      wr(TMR_CTRL, 32'h8);                 // leaves COUNT at 5
      rd_chk("pause_count5", TMR_COUNT, 32'd5);
      repeat (3) tick();
      rd_chk("pause_hold5", TMR_COUNT, 32'd5);
      st_chk("pause_idle", ST_IDLE);
      wr(TMR_CTRL, 32'h9);
      tick();
      st_chk("resume_load", ST_LOAD);
      tick();
      rd_chk("resume_reload", TMR_COUNT, 32'd20);
      wr(TMR_CTRL, 32'h8);
      repeat (2) tick();

      // ---- async reset drops a live irq pulse ----
      wr(TMR_PRESET, 32'd1);
      wr(TMR_CTRL, 32'hB);
      n = 0; found = 1'b0;
      while (!found && n < 50) begin
         tick(); n++;
         found = irq;
      end
      chk("ar_rst_irq_seen", {31'd0, found}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_irq_drop", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- async reset mid-count ----
      wr(TMR_PRESET, 32'd30);
      wr(TMR_CTRL, 32'h9);
      n = 0; found = 1'b0;
      while (!found && n < 100) begin
         addr = TMR_COUNT; #1;
         found = (rdata == 32'd7);
         if (!found) begin tick(); n++; end
      end
      chk("rst_reach7", {31'd0, found}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_count0", rdata, 32'd0);
      chk("async_irq0", {31'd0, irq}, 32'd0);
      st_chk("async_idle", ST_IDLE);
      rd_chk("async_preset0", TMR_PRESET, 32'd0);
      rd_chk("async_ctrl0", TMR_CTRL, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("post_rst_irq", {31'd0, irq}, 32'd0);
      end
      rd_chk("post_rst_count", TMR_COUNT, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
